mdu_sequencer: RTL and testbench

//  Sequences the shared multiply/divide resource (HI/LO) in the E stage of the pipelined MIPS core.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_calc.sv | 53 +++++
 rtl/mdu_sequencer.sv | 120 ++++++++++++
 tb/tb_mdu_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and small op-class helpers.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_md_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: produces the {HI,LO} result for one
// MD op plus a divide-by-zero flag so the sequencer can suppress the commit.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_res_o,
    output logic [31:0] lo_res_o,
    output logic        div_zero_o
);

    logic signed [63:0] sProd;
    logic        [63:0] uProd;
    logic        [31:0] safeSB;
    logic        [31:0] safeUB;
    logic signed [31:0] sQuot;
    logic signed [31:0] sRem;
    logic               divOverflow;

    assign sProd = 64'($signed(a_i)) * 64'($signed(b_i));
    assign uProd = {32'd0, a_i} * {32'd0, b_i};

    // Divisor of 1 stands in for both a zero divisor and MIN/-1; for MIN/-1 it
    // also yields the architectural answer (quotient = dividend, remainder = 0).
    assign divOverflow = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign safeSB      = ((b_i == 32'd0) || divOverflow) ? 32'd1 : b_i;
    assign safeUB      = (b_i == 32'd0) ? 32'd1 : b_i;
    assign sQuot       = $signed(a_i) / $signed(safeSB);
    assign sRem        = $signed(a_i) % $signed(safeSB);

    assign div_zero_o  = is_md_div(op_i) && (b_i == 32'd0);

    always_comb begin
        hi_res_o = 32'd0;
        lo_res_o = 32'd0;
        case (op_i)
            MD_MULT:  {hi_res_o, lo_res_o} = sProd;
            MD_MULTU: {hi_res_o, lo_res_o} = uProd;
            MD_DIV: begin
                hi_res_o = sRem;
                lo_res_o = sQuot;
            end
            MD_DIVU: begin
                hi_res_o = a_i % safeUB;
                lo_res_o = a_i / safeUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer: holds HI/LO, models mult/div latency with a
// down-counter and exposes busy to the hazard unit.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush_req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pendHi_q, pendHi_d, pendLo_q, pendLo_d;
    logic        divZero_q, divZero_d;

    logic [31:0] calcHi;
    logic [31:0] calcLo;
    logic        calcDivZero;

    mdu_calc u_calc (
        .op_i       (md_op),
        .a_i        (rs_val),
        .b_i        (rt_val),
        .hi_res_o   (calcHi),
        .lo_res_o   (calcLo),
        .div_zero_o (calcDivZero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pendHi_q  <= 32'd0;
            pendLo_q  <= 32'd0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pendHi_q  <= pendHi_d;
            pendLo_q  <= pendLo_d;
            divZero_q <= divZero_d;
        end
    end

    // A flush in IDLE cancels the E-stage op; once RUN the op is past E and must finish.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pendHi_d  = pendHi_q;
        pendLo_d  = pendLo_q;
        divZero_d = divZero_q;
        case (state_q)
            ST_IDLE: begin
                if (!flush_req) begin
                    if (start && is_md_start(md_op)) begin
                        pendHi_d  = calcHi;
                        pendLo_d  = calcLo;
                        divZero_d = calcDivZero;
                        cnt_d     = is_md_div(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_d   = ST_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = rs_val;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    if (!divZero_q) begin
                        hi_d = pendHi_q;
                        lo_d = pendLo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        md_out = 32'd0;
        if (md_op == MD_MFHI) begin
            md_out = hi_q;
        end else if (md_op == MD_MFLO) begin
            md_out = lo_q;
        end
    end

    // The hazard unit must hold further MD writers in D while an op is in flight.
    assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_RUN) |-> !((start && is_md_start(md_op)) ||
                                  (md_op == MD_MTHI) || (md_op == MD_MTLO)));

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: a cycle-level reference model of HI/LO
// and busy compared every cycle, plus directed ops with hand-computed results.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush_req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int checks = 0;
    int errors = 0;

    mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .flush_req (flush_req),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .md_out    (md_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: remaining busy cycles and a pending result that lands when
    // the count runs out; results come from plain integer arithmetic.
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    logic [31:0] mPHi = 32'd0;
    logic [31:0] mPLo = 32'd0;
    int          mRem = 0;
    bit          mCommit = 1'b0;
    bit          cmpEn = 1'b0;

    function automatic void modelStart();
        longint          sp;
        longint unsigned up;
        int              a;
        int              b;
        a       = rs_val;
        b       = rt_val;
        mCommit = 1'b1;
        case (md_op)
            MD_MULT: begin
                sp = longint'(a) * longint'(b);
                {mPHi, mPLo} = sp;
            end
            MD_MULTU: begin
                up = longint'({32'd0, rs_val}) * longint'({32'd0, rt_val});
                {mPHi, mPLo} = up;
            end
            MD_DIV: begin
                if (b == 0) mCommit = 1'b0;
                else if (a == 32'h8000_0000 && b == -1) begin
                    mPLo = 32'h8000_0000;
                    mPHi = 32'd0;
                end else begin
                    mPLo = a / b;
                    mPHi = a % b;
                end
            end
            default: begin
                if (rt_val == 32'd0) mCommit = 1'b0;
                else begin
                    mPLo = rs_val / rt_val;
                    mPHi = rs_val % rt_val;
                end
            end
        endcase
        mRem = (md_op == MD_DIV || md_op == MD_DIVU) ? DC : MC;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mHi = 32'd0;
            mLo = 32'd0;
            mRem = 0;
            mCommit = 1'b0;
            cmpEn = 1'b1;
        end else if (mRem > 0) begin
            mRem--;
            if (mRem == 0 && mCommit) begin
                mHi = mPHi;
                mLo = mPLo;
            end
        end else if (!flush_req) begin
            if (start && (md_op == MD_MULT || md_op == MD_MULTU ||
                          md_op == MD_DIV || md_op == MD_DIVU)) modelStart();
            else if (md_op == MD_MTHI) mHi = rs_val;
            else if (md_op == MD_MTLO) mLo = rs_val;
        end
    end

    // Every cycle after the first reset edge the DUT must match the model.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("busy", {31'd0, busy}, {31'd0, mRem > 0});
            checkOutput("hi", hi, mHi);
            checkOutput("lo", lo, mLo);
            checkOutput("md_out", md_out,
                        (md_op == MD_MFHI) ? mHi : (md_op == MD_MFLO) ? mLo : 32'd0);
        end
    end

    // Presents one op for exactly one cycle, then returns the bus to MD_NONE.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic st, input logic fl);
        @(posedge clk); #1;
        md_op = op; rs_val = a; rt_val = b; start = st; flush_req = fl;
        @(posedge clk); #1;
        md_op = MD_NONE; start = 1'b0; flush_req = 1'b0;
    endtask

    // Counts busy cycles until busy drops, with a hard cycle budget.
    task automatic waitIdle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
    endtask

    task automatic readMd(input logic [3:0] op, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        md_op = op;
        @(negedge clk);
        checkOutput(name, md_out, exp);
        @(posedge clk); #1;
        md_op = MD_NONE;
    endtask

    int n;

    initial begin
        reset = 1'b1; start = 1'b0; md_op = MD_NONE;
        rs_val = 32'd0; rt_val = 32'd0; flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);

        // Signed multiply of a negative operand
        applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
        waitIdle(n);
        checkOutput("mult_cycles", n, 32'd5);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFEB);

        // Unsigned and signed divides, including the MIN/-1 overflow case
        applyStimulus(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
        waitIdle(n);
        checkOutput("divu_cycles", n, 32'd10);
        checkOutput("divu_lo", lo, 32'd14);
        checkOutput("divu_hi", hi, 32'd2);
        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        waitIdle(n);
        checkOutput("div_neg_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_neg_hi", hi, 32'hFFFF_FFFF);
        applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        waitIdle(n);
        checkOutput("div_ovf_lo", lo, 32'h8000_0000);
        checkOutput("div_ovf_hi", hi, 32'd0);

        // Divide by zero keeps the values written by MTHI/MTLO
        applyStimulus(MD_MTHI, 32'd5, 32'd0, 1'b0, 1'b0);
        applyStimulus(MD_MTLO, 32'd9, 32'd0, 1'b0, 1'b0);
        applyStimulus(MD_DIV, 32'd77, 32'd0, 1'b1, 1'b0);
        waitIdle(n);
        checkOutput("divz_cycles", n, 32'd10);
        checkOutput("divz_hi", hi, 32'd5);
        checkOutput("divz_lo", lo, 32'd9);

        // Flush alongside start cancels; flush mid-run does not
        applyStimulus(MD_MULTU, 32'd3, 32'd4, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("flush_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_hi", hi, 32'd5);
        checkOutput("flush_lo", lo, 32'd9);
        applyStimulus(MD_MULTU, 32'h0001_0001, 32'h0001_0000, 1'b1, 1'b0);
        @(posedge clk); #1 flush_req = 1'b1;
        @(posedge clk); #1 flush_req = 1'b0;
        waitIdle(n);
        checkOutput("midflush_cycles", n, 32'd3);
        checkOutput("midflush_hi", hi, 32'd1);
        checkOutput("midflush_lo", lo, 32'h0001_0000);

        // Reset in the third busy cycle of a divide
        applyStimulus(MD_DIV, 32'd50, 32'd3, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_hi", hi, 32'd0);
        checkOutput("midreset_lo", lo, 32'd0);
        applyStimulus(MD_MULT, 32'd2, 32'd3, 1'b1, 1'b0);
        waitIdle(n);
        checkOutput("mult23_cycles", n, 32'd5);
        checkOutput("mult23_lo", lo, 32'd6);
        checkOutput("mult23_hi", hi, 32'd0);

        // Move-to followed by move-from reads
        applyStimulus(MD_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        readMd(MD_MFLO, 32'hDEAD_BEEF, "mflo");
        applyStimulus(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        readMd(MD_MFHI, 32'h1234_5678, "mfhi");
        readMd(MD_NONE, 32'd0, "md_none");

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
